core_inst_seq: RTL and testbench
================================

Name: core_inst_seq

Overview:
- Instruction sequencer that drives the 34-bit instruction word and the D_xmem data bus of the core for one tile.
- It takes a host word stream (activations, then kernel), writes that stream into xmem, and moves the kernel into L0 and then into the PEs.
- It then streams activations through L0 with execute, and drains the OFIFO into pmem.
- It sits between the testbench/host and the core, and is the producer end of the core's inst/D_xmem interface.

Parameters:
row, 8, PE array rows; sets D_xmem width
col, 8, PE array columns; number of kernel words
bw, 4, activation/weight bit width
A_ACT, 11'd0, xmem base address of activations
A_W, 11'd1024, xmem base address of kernel words
A_PSUM, 11'd0, pmem base address for drained psums

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse; accepted only in IDLE
n_act  in  11  activation word count (1..1024); latched on accepted start
in_valid  in  1  host word valid
in_data  in  bw*row  host word
in_ready  out  1  high in XW state; a word transfers when in_valid&in_ready
ofifo_valid  in  1  core OFIFO has data
inst  out  34  registered instruction word
D_xmem  out  bw*row  registered xmem write data
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on DONE->IDLE

Behaviour:
- inst field map:
  - [33] acc
  - [32] CEN_pmem
  - [31] WEN_pmem
  - [30:20] A_pmem
  - [19] CEN_xmem
  - [18] WEN_xmem
  - [17:7] A_xmem
  - [6] ofifo_rd
  - [5] ififo_wr
  - [4] ififo_rd
  - [3] l0_rd
  - [2] l0_wr
  - [1] execute
  - [0] load
- CEN and WEN are active-low.
- Idle word: 34'h1800C0000 (both CENs and both WENs high, all else 0). acc, ififo_wr and ififo_rd are always 0.
- Reset (reset low, async): state=IDLE, inst=idle word, D_xmem=0, in_ready=0, busy=0, done=0, all counters 0. Reset mid-tile aborts immediately; no done pulse.
- All outputs are registered. A field decided in cycle t appears on inst in t+1. xmem read data is valid at the core one cycle after the read inst.
- FSM, with cnt as a shared 11-bit counter cleared on every state entry:
  - IDLE: start -> XW, latch n_act. start in any other state is ignored.
  - XW: in_ready=1.
    - Each handshake emits CEN_xmem=0, WEN_xmem=0, D_xmem=in_data.
    - A_xmem=A_ACT+cnt for cnt<n_act, else A_W+(cnt-n_act).
    - Without a handshake, emit the idle word.
    - After n_act+col words -> WL0.
  - WL0: col read cycles, CEN_xmem=0, WEN_xmem=1, A_xmem=A_W+cnt.
    - l0_wr is asserted delayed by one cycle to cover SRAM latency, giving exactly col l0_wr cycles.
    - Then -> WLD.
  - WLD: col cycles of l0_rd=1 and load=1, then row cycles of idle word (kernel propagation gap), then -> AL0.
  - AL0: same as WL0 but n_act reads from A_ACT+cnt, with n_act delayed l0_wr cycles, then -> EX.
  - EX: n_act cycles of l0_rd=1 and execute=1, then -> DR.
  - DR: each cycle ofifo_valid=1 and dcnt<n_act, emit ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=A_PSUM+dcnt, and increment dcnt.
    - When dcnt reaches n_act -> DONE.
    - ofifo_valid low gives the idle word (stall); there is no timeout.
  - DONE: one cycle of idle word, done=1 registered, -> IDLE.
- Address arithmetic is 11-bit modulo 2048 (wraps). n_act=0 is treated as 1.
- No load and execute are ever asserted in the same cycle. l0_wr and l0_rd are never asserted together.

Test Plan:
- Reset held low with start=1 -> inst=34'h1800C0000, D_xmem=0, busy=0, in_ready=0; after release, state stays IDLE until start.
- start, n_act=4, host sends 12 words with in_valid toggling every other cycle -> 12 writes: A_xmem 0,1,2,3 then 1024..1031; D_xmem matches in_data; idle words in gap cycles.
- After XW -> 8 reads A_xmem 1024..1031; l0_wr high for 8 cycles starting one cycle after the first read; then 8 load=l0_rd=1 cycles; then 8 idle cycles.
- EX with n_act=4 -> exactly 4 consecutive execute=l0_rd=1 cycles; load=0 throughout.
- DR: ofifo_valid pattern 1,0,1,1,0,1 -> ofifo_rd only in valid cycles; A_pmem 0,1,2,3; then done pulses once, busy falls the same cycle.
- reset asserted during EX -> inst returns to idle word asynchronously; no done pulse; a new start runs a full tile from XW.

Source files
------------

// File: rtl/core_inst_seq_if.sv
// Host/core-facing bundle of the instruction sequencer: host word stream,
// tile control, OFIFO status in; instruction word, xmem write data and status out.
// master = sequencer side, slave = host/core side. No internal logic.
interface core_inst_seq_if #(
  parameter int row = 8,
  parameter int bw  = 4
);
  logic                start;        // one-cycle tile start pulse
  logic [10:0]         n_act;        // activation word count, latched on start
  logic                in_valid;     // host word valid
  logic [bw*row-1:0]   in_data;      // host word (activations, then kernel)
  logic                in_ready;     // sequencer accepts host words
  logic                ofifo_valid;  // core OFIFO holds a psum row
  logic [33:0]         inst;         // registered instruction word to the core
  logic [bw*row-1:0]   D_xmem;       // registered xmem write data
  logic                busy;         // tile in progress
  logic                done;         // one-cycle tile completion pulse

  modport master (
    input  start, n_act, in_valid, in_data, ofifo_valid,
    output in_ready, inst, D_xmem, busy, done
  );

  modport slave (
    output start, n_act, in_valid, in_data, ofifo_valid,
    input  in_ready, inst, D_xmem, busy, done
  );
endinterface

// File: rtl/core_inst_seq.sv
// Tile sequencer: host words -> xmem, kernel xmem->L0->PEs, activations xmem->L0->execute, OFIFO->pmem.
// Latency: every output is registered; a field decided in cycle t shows on inst/D_xmem in t+1.
// Backpressure: host stalled via in_ready (XW only); drain stalls on ofifo_valid low with no timeout.
// Ports: clk, reset (async active-low), bus (core_inst_seq_if.master: start/n_act/in_*/ofifo_valid in,
//        in_ready/inst/D_xmem/busy/done out).
module core_inst_seq #(
  parameter int          row    = 8,
  parameter int          col    = 8,
  parameter int          bw     = 4,
  parameter logic [10:0] A_ACT  = 11'd0,
  parameter logic [10:0] A_W    = 11'd1024,
  parameter logic [10:0] A_PSUM = 11'd0
) (
  input  logic            clk,
  input  logic            reset,
  core_inst_seq_if.master bus
);
  localparam int          DW        = bw * row;
  localparam logic [33:0] IDLE_WORD = 34'h1800C0000;
  localparam logic [10:0] COL_N     = 11'(col);
  localparam logic [10:0] ROW_N     = 11'(row);

  typedef enum logic [2:0] {
    S_IDLE, S_XW, S_WL0, S_WLD, S_AL0, S_EX, S_DR, S_DONE
  } state_t;

  state_t          state, state_n;
  logic [10:0]     cnt, cnt_n;
  logic [10:0]     n_lat, n_lat_n;
  logic [33:0]     inst_q, inst_n;
  logic [DW-1:0]   d_q, d_n;
  logic            ready_q, busy_q, done_q;
  logic            hs;
  logic [10:0]     xw_last, wld_last, n_last;

  assign hs       = bus.in_valid & ready_q;
  assign xw_last  = n_lat + COL_N - 11'd1;
  assign wld_last = COL_N + ROW_N - 11'd1;
  assign n_last   = n_lat - 11'd1;

  // L0 fill states run one cycle longer than their read count: reads go out
  // for cnt < len and l0_wr trails them by one cycle (cnt >= 1), so the xmem
  // read latency is covered and l0_wr never overlaps the following l0_rd.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    n_lat_n = n_lat;
    inst_n  = IDLE_WORD;
    d_n     = d_q;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_XW;
          cnt_n   = 11'd0;
          n_lat_n = (bus.n_act == 11'd0) ? 11'd1 : bus.n_act;
        end
      end
      S_XW: begin
        if (hs) begin
          inst_n[19]   = 1'b0;
          inst_n[18]   = 1'b0;
          inst_n[17:7] = (cnt < n_lat) ? (A_ACT + cnt) : (A_W + (cnt - n_lat));
          d_n          = bus.in_data;
          cnt_n        = cnt + 11'd1;
          if (cnt == xw_last) begin
            state_n = S_WL0;
            cnt_n   = 11'd0;
          end
        end
      end
      S_WL0: begin
        if (cnt < COL_N) begin
          inst_n[19]   = 1'b0;
          inst_n[17:7] = A_W + cnt;
        end
        inst_n[2] = (cnt != 11'd0);
        cnt_n     = cnt + 11'd1;
        if (cnt == COL_N) begin
          state_n = S_WLD;
          cnt_n   = 11'd0;
        end
      end
      S_WLD: begin
        // col load cycles, then row idle cycles while weights ripple down
        if (cnt < COL_N) begin
          inst_n[3] = 1'b1;
          inst_n[0] = 1'b1;
        end
        cnt_n = cnt + 11'd1;
        if (cnt == wld_last) begin
          state_n = S_AL0;
          cnt_n   = 11'd0;
        end
      end
      S_AL0: begin
        if (cnt < n_lat) begin
          inst_n[19]   = 1'b0;
          inst_n[17:7] = A_ACT + cnt;
        end
        inst_n[2] = (cnt != 11'd0);
        cnt_n     = cnt + 11'd1;
        if (cnt == n_lat) begin
          state_n = S_EX;
          cnt_n   = 11'd0;
        end
      end
      S_EX: begin
        inst_n[3] = 1'b1;
        inst_n[1] = 1'b1;
        cnt_n     = cnt + 11'd1;
        if (cnt == n_last) begin
          state_n = S_DR;
          cnt_n   = 11'd0;
        end
      end
      S_DR: begin
        // cnt doubles as the drained-psum count here
        if (bus.ofifo_valid && (cnt < n_lat)) begin
          inst_n[6]     = 1'b1;
          inst_n[32]    = 1'b0;
          inst_n[31]    = 1'b0;
          inst_n[30:20] = A_PSUM + cnt;
          cnt_n         = cnt + 11'd1;
          if (cnt == n_last) begin
            state_n = S_DONE;
            cnt_n   = 11'd0;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        cnt_n   = 11'd0;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 11'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= 11'd0;
      n_lat   <= 11'd0;
      inst_q  <= IDLE_WORD;
      d_q     <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      n_lat   <= n_lat_n;
      inst_q  <= inst_n;
      d_q     <= d_n;
      ready_q <= (state_n == S_XW);
      busy_q  <= (state_n != S_IDLE);
      // lands in the first IDLE cycle, together with busy falling
      done_q  <= (state == S_DONE);
    end
  end

  assign bus.inst     = inst_q;
  assign bus.D_xmem   = d_q;
  assign bus.in_ready = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_core_inst_seq.sv
// Bench for core_inst_seq: directed and random tiles, each recorded cycle by cycle
// and then judged against the tile rules (write/read address lists, l0_wr trailing
// reads, load/execute windows, drain vs ofifo_valid, done/busy timing).
module tb_core_inst_seq;
  localparam int          ROW  = 8;
  localparam int          COL  = 8;
  localparam int          BW   = 4;
  localparam logic [10:0] AACT = 11'd0;
  localparam logic [10:0] AW   = 11'd1024;
  localparam logic [10:0] APS  = 11'd0;
  localparam logic [33:0] IDLE_WORD = 34'h1800C0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [5:0] pat_bits = 6'b101101;  // ofifo_valid 1,0,1,1,0,1 (bit0 first)

  core_inst_seq_if #(.row(ROW), .bw(BW)) bus ();

  core_inst_seq #(.row(ROW), .col(COL), .bw(BW), .A_ACT(AACT), .A_W(AW), .A_PSUM(APS))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_wr(input logic [33:0] w);
    return (w[19] == 1'b0) && (w[18] == 1'b0);
  endfunction

  function automatic bit is_rd(input logic [33:0] w);
    return (w[19] == 1'b0) && (w[18] == 1'b1);
  endfunction

  task automatic run_tile(input int n_req, input bit rnd, input bit abort);
    int n, total, sent, cyc, ex_seen, done_cnt, post, k, nc;
    int wi, werr, derr, gerr, first_rd, ri, raerr, l0err, nl0w, last_wwl, last_l0w;
    int nload, f, lerr, g2, nex, e0, xerr, inv, ds, rem, drerr, nrd, paerr, pmerr;
    int last_rd, done_idx, berr, dn_after;
    bit in_dr, stop, tmo, v, o, exp_rd;
    logic [10:0] exp_a;
    logic [31:0] words[$];
    logic [33:0] ins[$];
    logic [31:0] dx[$];
    bit bs[$];
    bit dn[$];
    bit ov[$];
    n = (n_req == 0) ? 1 : n_req;
    total = n + COL;
    sent = 0; cyc = 0; ex_seen = 0; done_cnt = 0; post = 0; k = 0;
    in_dr = 0; stop = 0; tmo = 0;
    for (int i = 0; i < total; i++) words.push_back($urandom);
    bus.start = 1'b1;
    bus.n_act = 11'(n_req);
    @(posedge clk); #1;
    while (!stop) begin
      ins.push_back(bus.inst);
      dx.push_back(bus.D_xmem);
      bs.push_back(bus.busy);
      dn.push_back(bus.done);
      if (bus.done) done_cnt++;
      if (bus.inst[1]) ex_seen++;
      if (ex_seen == n) in_dr = 1;
      if (abort && ex_seen == 2) begin
        #3 reset = 1'b0;
        #1;
        chk("abort_inst_idle", bus.inst, IDLE_WORD);
        chk("abort_busy", bus.busy, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_dxmem", bus.D_xmem, 0);
        chk("abort_done", bus.done, 0);
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.ofifo_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        dn_after = 0;
        repeat (5) begin
          @(posedge clk); #1;
          if (bus.done || bus.busy) dn_after++;
        end
        chk("abort_no_done_no_busy", dn_after, 0);
        stop = 1;
      end else begin
        bus.start = rnd && bus.busy && (done_cnt == 0) && ($urandom_range(0, 5) == 0);
        if (rnd) bus.n_act = 11'($urandom);
        v = (sent < total) && (rnd ? ($urandom_range(0, 2) != 0) : (cyc % 2 == 0));
        bus.in_valid = v;
        bus.in_data = (sent < total) ? words[sent] : 32'd0;
        if (v && bus.in_ready) sent++;
        o = in_dr && (done_cnt == 0) && (rnd ? ($urandom_range(0, 1) == 1) : pat_bits[k % 6]);
        if (in_dr) k++;
        bus.ofifo_valid = o;
        ov.push_back(o);
        if (done_cnt > 0) post++;
        cyc++;
        if (post >= 4) stop = 1;
        else if (cyc >= 4000) begin tmo = 1; stop = 1; end
        else begin @(posedge clk); #1; end
      end
    end
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.ofifo_valid = 1'b0;
    if (abort) return;
    chk("tile_timeout", tmo, 0);
    nc = ins.size();

    // xmem writes: n activations then col kernel words, in host order
    wi = 0; werr = 0; derr = 0; gerr = 0; first_rd = -1;
    for (int c = 0; c < nc; c++) if (is_rd(ins[c]) && first_rd < 0) first_rd = c;
    for (int c = 0; c < nc; c++) begin
      if (is_wr(ins[c])) begin
        exp_a = (wi < n) ? AACT + 11'(wi) : AW + 11'(wi - n);
        if (wi < total) begin
          if (ins[c][17:7] !== exp_a) werr++;
          if (dx[c] !== words[wi]) derr++;
        end
        wi++;
      end else if (first_rd < 0 || c < first_rd) begin
        if (ins[c] !== IDLE_WORD) gerr++;
      end
    end
    chk("xmem_wr_count", wi, total);
    chk("xmem_wr_addr_errs", werr, 0);
    chk("xmem_wr_data_errs", derr, 0);
    chk("xw_idle_gap_errs", gerr, 0);

    // xmem reads: kernel words then activations; l0_wr exactly one cycle behind each read
    ri = 0; raerr = 0; l0err = 0; nl0w = 0; last_wwl = -1; last_l0w = -1;
    for (int c = 0; c < nc; c++) begin
      if (is_rd(ins[c])) begin
        exp_a = (ri < COL) ? AW + 11'(ri) : AACT + 11'(ri - COL);
        if (ins[c][17:7] !== exp_a) raerr++;
        ri++;
      end
      if (ins[c][2] !== ((c > 0) && is_rd(ins[c-1]))) l0err++;
      if (ins[c][2]) begin
        nl0w++;
        last_l0w = c;
        if (nl0w == COL) last_wwl = c;
      end
    end
    chk("xmem_rd_count", ri, COL + n);
    chk("xmem_rd_addr_errs", raerr, 0);
    chk("l0_wr_follows_read_errs", l0err, 0);
    chk("l0_wr_count", nl0w, COL + n);

    // load window, propagation gap, execute window, global exclusions
    nload = 0; f = -1; nex = 0; e0 = -1; inv = 0;
    for (int c = 0; c < nc; c++) begin
      if (ins[c][0]) begin nload++; if (f < 0) f = c; end
      if (ins[c][1]) begin nex++; if (e0 < 0) e0 = c; end
      if ((ins[c][0] && ins[c][1]) || (ins[c][2] && ins[c][3]) ||
          ins[c][33] || ins[c][5] || ins[c][4]) inv++;
    end
    lerr = 0; g2 = 0; xerr = 0;
    for (int c = f; c < f + COL; c++)
      if (c < 0 || c >= nc || !(ins[c][0] && ins[c][3])) lerr++;
    for (int c = f + COL; c < f + COL + ROW; c++)
      if (c < 0 || c >= nc || ins[c] !== IDLE_WORD) g2++;
    for (int c = e0; c < e0 + n; c++)
      if (c < 0 || c >= nc || !(ins[c][1] && ins[c][3] && !ins[c][0])) xerr++;
    chk("load_count", nload, COL);
    chk("load_window_errs", lerr, 0);
    chk("load_after_kernel_l0_wr", (f > last_wwl), 1);
    chk("kernel_gap_errs", g2, 0);
    chk("act_read_after_gap", (f >= 0 && f + COL + ROW < nc) ? is_rd(ins[f + COL + ROW]) : 0, 1);
    chk("exec_count", nex, n);
    chk("exec_window_errs", xerr, 0);
    chk("exec_after_act_l0_wr", (e0 > last_l0w), 1);
    chk("exclusion_violations", inv, 0);

    // drain: read one cycle after each ofifo_valid until n psums are taken
    ds = (e0 < 0) ? nc : e0 + n - 1;
    rem = n; drerr = 0; nrd = 0; paerr = 0; pmerr = 0; last_rd = -1;
    for (int c = 0; c < nc; c++) begin
      exp_rd = 0;
      if (c > 0 && c - 1 >= ds && rem > 0 && ov[c-1]) begin exp_rd = 1; rem--; end
      if (ins[c][6] !== exp_rd) drerr++;
      if ((!ins[c][32] && !ins[c][31]) !== ins[c][6]) pmerr++;
      if (ins[c][6]) begin
        if (ins[c][30:20] !== APS + 11'(nrd)) paerr++;
        nrd++;
        last_rd = c;
      end
    end
    chk("ofifo_rd_count", nrd, n);
    chk("ofifo_rd_vs_valid_errs", drerr, 0);
    chk("pmem_addr_errs", paerr, 0);
    chk("pmem_strobe_errs", pmerr, 0);

    // done once, right after the DONE idle cycle; busy falls with it
    done_idx = -1; berr = 0;
    for (int c = 0; c < nc; c++) if (dn[c] && done_idx < 0) done_idx = c;
    for (int c = 0; c < done_idx; c++) if (!bs[c]) berr++;
    chk("done_pulse_count", done_cnt, 1);
    chk("done_cycle", done_idx, last_rd + 1);
    chk("busy_low_at_done", (done_idx >= 0) ? bs[done_idx] : 1'b1, 0);
    chk("busy_high_during_tile", berr, 0);
    chk("idle_word_at_done", (done_idx >= 0) ? ins[done_idx] : 34'd0, IDLE_WORD);
  endtask

  initial begin
    int bad;
    bus.start = 1'b1; bus.n_act = 11'd5; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.ofifo_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_inst", bus.inst, IDLE_WORD);
    chk("reset_dxmem", bus.D_xmem, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_done", bus.done, 0);
    bus.start = 1'b0;
    reset = 1'b1;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.busy || bus.in_ready || bus.inst !== IDLE_WORD) bad++;
    end
    chk("idle_until_start", bad, 0);

    run_tile(4, 1'b0, 1'b0);
    run_tile(0, 1'b1, 1'b0);
    run_tile(1, 1'b1, 1'b0);
    run_tile(40, 1'b1, 1'b0);
    for (int t = 0; t < 4; t++) run_tile($urandom_range(2, 24), 1'b1, 1'b0);
    run_tile(6, 1'b1, 1'b1);
    run_tile(5, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
